// File: rtl/sr_latch_driver_if.sv
// Request/latch-drive bundle for sr_latch_driver: requester handshake, active-low
// latch drive, latch readback and status.
interface sr_latch_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic s_n;
  logic r_n;
  logic q;
  logic q_not;
  logic busy;
  logic err;

  // master: the requester side, which also presents the latch readback
  modport master (
    output req_valid, req_level, q, q_not,
    input  req_ready, s_n, r_n, busy, err
  );

  modport slave (
    input  req_valid, req_level, q, q_not,
    output req_ready, s_n, r_n, busy, err
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Clocked front end for an SR latch: one timed active-low set/reset pulse per request.
// Optional readback check of q/q_not enabled by macro SR_LATCH_DRIVER_READBACK_EN.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input logic              clk,
  input logic              rst,
  sr_latch_driver_if.slave bus
);

  localparam int unsigned MAX_CNT = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE_SET,
    PULSE_RESET,
    CHECK,
    GAP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lvl_q;
  logic             s_n_q;
  logic             r_n_q;
  logic             ready_q;
  logic             busy_q;
`ifdef SR_LATCH_DRIVER_READBACK_EN
  logic             err_q;
`endif

  // s_n and r_n are only ever pulled low in their own pulse state, so they can
  // never be low together, and both are reset high asynchronously.
  // NOTE: every output is a flop, so the async reset forces the latch drive
  // inactive immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      s_n_q   <= 1'b1;
      r_n_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SR_LATCH_DRIVER_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            lvl_q   <= bus.req_level;
            cnt_q   <= CNT_W'(PULSE_CYCLES);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.req_level) begin
              state_q <= PULSE_SET;
              s_n_q   <= 1'b0;
            end else begin
              state_q <= PULSE_RESET;
              r_n_q   <= 1'b0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end

        PULSE_SET, PULSE_RESET: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= CHECK;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        CHECK: begin
`ifdef SR_LATCH_DRIVER_READBACK_EN
          if ((bus.q != lvl_q) || (bus.q_not != ~lvl_q)) begin
            err_q <= 1'b1;
          end
`endif
          if (GAP_CYCLES != 0) begin
            state_q <= GAP;
            cnt_q   <= CNT_W'(GAP_CYCLES);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end

        GAP: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          s_n_q   <= 1'b1;
          r_n_q   <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_n       = s_n_q;
  assign bus.r_n       = r_n_q;
  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  assign bus.err = err_q;
`else
  logic unused_readback;
  assign unused_readback = ^{bus.q, bus.q_not, lvl_q};
  assign bus.err         = 1'b0;
`endif

endmodule
